// File: rtl/spi_regfile_pkg.sv
// Shared constants and FSM encoding for the SPI slave register file.
package spi_regfile_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int ADDR_W     = 2;
    localparam int NUM_REGS   = 4;
    localparam int BYTE_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with one-clk rise/fall pulses.
// The chain resets low, so an input already low after reset never produces a fall pulse.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave that writes four 8-bit display registers, with burst auto-increment.
// Define SPI_READBACK_EN to enable shifting register contents out on miso for read commands.
module spi_slave_regfile
    import spi_regfile_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter logic [BYTE_BITS-1:0] RESET_VAL   = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 ss_n,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [BYTE_BITS-1:0] slv_reg0,
    output logic [BYTE_BITS-1:0] slv_reg1,
    output logic [BYTE_BITS-1:0] slv_reg2,
    output logic [BYTE_BITS-1:0] slv_reg3,
    output logic                 wr_pulse,
    output logic [ADDR_W-1:0]    wr_addr
);

    logic sclk_sync, sclk_rise;
    logic ss_sync, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
`ifdef SPI_READBACK_EN
    logic sclk_fall;
`else
    logic sclk_fall_unused;
`endif

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .sync (sclk_sync),
        .rise (sclk_rise),
`ifdef SPI_READBACK_EN
        .fall (sclk_fall)
`else
        .fall (sclk_fall_unused)
`endif
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_n),
        .sync (ss_sync),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .sync (mosi_sync),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    state_t                 state, state_nxt;
    logic [2:0]             bit_cnt;
    logic [BYTE_BITS-2:0]   rx_shift;
    logic [BYTE_BITS-1:0]   rx_byte;
    logic                   rw;
    logic [ADDR_W-1:0]      addr, addr_inc;
    logic [BYTE_BITS-1:0]   regs [NUM_REGS];
    logic                   shift_en, cmd_done, data_done, clr_cnt;

    // rx_byte is the byte as it will look once the current mosi bit is shifted in.
    assign rx_byte  = {rx_shift, mosi_sync};
    assign addr_inc = addr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ss_n rising edge outranks any sclk edge in the same clk.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cmd_done  = 1'b0;
        data_done = 1'b0;
        clr_cnt   = 1'b0;
        if (ss_rise) begin
            state_nxt = IDLE;
            clr_cnt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state_nxt = CMD;
                        clr_cnt   = 1'b1;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            cmd_done  = 1'b1;
                            state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 3'd7) data_done = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // bit_cnt rolls 7 -> 0 on its own, which is the clear after each byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rw       <= 1'b0;
            addr     <= '0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_pulse <= 1'b0;
            if (clr_cnt)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) rx_shift <= rx_byte[BYTE_BITS-2:0];
            if (cmd_done) begin
                rw   <= rx_byte[CMD_RW_BIT];
                addr <= rx_byte[ADDR_W-1:0];
            end
            if (data_done) begin
                if (rw) begin
                    regs[addr] <= rx_byte;
                    wr_pulse   <= 1'b1;
                    wr_addr    <= addr;
                end
                addr <= addr_inc;
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic [BYTE_BITS-1:0] tx_shift;
    logic                 tx_shift_en;

    // No shift while bit_cnt == 0, so bit 7 of a freshly loaded byte waits for its rising edge.
    assign tx_shift_en = (state == DATA) && sclk_fall && (bit_cnt != 3'd0) && !ss_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
        end else if (cmd_done && !rx_byte[CMD_RW_BIT]) begin
            tx_shift <= regs[rx_byte[ADDR_W-1:0]];
        end else if (data_done && !rw) begin
            tx_shift <= regs[addr_inc];
        end else if (tx_shift_en) begin
            tx_shift <= {tx_shift[BYTE_BITS-2:0], 1'b0};
        end
    end

    assign miso_oe = !ss_sync && (state != IDLE);
    assign miso    = miso_oe ? tx_shift[BYTE_BITS-1] : 1'b0;
`else
    assign miso_oe = 1'b0;
    assign miso    = 1'b0;
`endif

    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed, table-driven bench for spi_slave_regfile: write/burst/read frames plus abort and reset cases.
module tb_spi_slave_regfile;

    localparam time HALF = 80ns;

    logic       clk, rst, sclk, mosi, ss_n;
    logic       miso, miso_oe, wr_pulse;
    logic [7:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic [1:0] wr_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected writes: {addr[1:0], data[7:0]}.
    logic [9:0] exp_q[$];

    spi_slave_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .slv_reg0 (slv_reg0),
        .slv_reg1 (slv_reg1),
        .slv_reg2 (slv_reg2),
        .slv_reg3 (slv_reg3),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5ns clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] reg_of(input int a);
        case (a)
            0:       return slv_reg0;
            1:       return slv_reg1;
            2:       return slv_reg2;
            default: return slv_reg3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name, input logic [31:0] exp);
        check({name, "_reg0"}, {24'h0, slv_reg0}, {24'h0, exp[31:24]});
        check({name, "_reg1"}, {24'h0, slv_reg1}, {24'h0, exp[23:16]});
        check({name, "_reg2"}, {24'h0, slv_reg2}, {24'h0, exp[15:8]});
        check({name, "_reg3"}, {24'h0, slv_reg3}, {24'h0, exp[7:0]});
    endtask

    // Write monitor: every wr_pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && wr_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_pulse", {30'h0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("wr_addr_data", {22'h0, wr_addr, reg_of(int'(wr_addr))}, {22'h0, e});
            end
        end
    end

    // Driver tasks
    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx, output logic oe);
        rx = 8'h00;
        oe = 1'b0;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = tx[i];
            #HALF;
            sclk  = 1'b1;
            rx[i] = miso;
            oe    = miso_oe;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        ss_n = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        ss_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spi_frame(input logic [31:0] bytes, input int n);
        logic [7:0] rx;
        logic       oe;
        spi_begin();
        for (int j = 0; j < n; j++) spi_bits(bytes[31-8*j -: 8], 8, rx, oe);
        spi_end();
    endtask

    // Vector table
    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic        rd_chk;
        logic [31:0] rd;
        int          nwr;
        logic [29:0] wr;
        logic [31:0] regs;
    } vec_t;

    vec_t vt[6];

    task automatic set_vec(input int i, input int n, input logic [31:0] bytes, input logic rd_chk,
                           input logic [31:0] rd, input int nwr, input logic [29:0] wr,
                           input logic [31:0] regs);
        vt[i].n = n; vt[i].bytes = bytes; vt[i].rd_chk = rd_chk; vt[i].rd = rd;
        vt[i].nwr = nwr; vt[i].wr = wr; vt[i].regs = regs;
    endtask

    logic       exp_oe;
    logic [7:0] rx_b;
    logic       oe_b;

    initial begin
`ifdef SPI_READBACK_EN
        exp_oe = 1'b1;
        set_vec(2, 3, 32'h0100_0000, 1'b1, 32'h0033_0000, 0, 30'h0, 32'h2233_0011);
        set_vec(4, 4, 32'h0200_0000, 1'b1, 32'h0000_1122, 0, 30'h0, 32'h2233_0011);
`else
        exp_oe = 1'b0;
        set_vec(2, 3, 32'h0100_0000, 1'b1, 32'h0000_0000, 0, 30'h0, 32'h2233_0011);
        set_vec(4, 4, 32'h0200_0000, 1'b1, 32'h0000_0000, 0, 30'h0, 32'h2233_0011);
`endif
        set_vec(0, 2, 32'h812A_0000, 1'b0, 32'h0, 1, {10'h12A, 20'h0},            32'h002A_0000);
        set_vec(1, 4, 32'h8311_2233, 1'b0, 32'h0, 3, {10'h311, 10'h022, 10'h133}, 32'h2233_0011);
        set_vec(3, 1, 32'h8000_0000, 1'b0, 32'h0, 0, 30'h0,                      32'h2233_0011);
        set_vec(5, 2, 32'h80A5_0000, 1'b0, 32'h0, 1, {10'h0A5, 20'h0},            32'hA533_0011);

        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        #50ns;
        rst = 1'b0;
        #200ns;
        check_regs("reset", 32'h0);
        check("reset_miso", {31'h0, miso}, 32'h0);
        check("reset_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("reset_wr_pulse", {31'h0, wr_pulse}, 32'h0);

        // sclk activity with ss_n high must be ignored
        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom_range(0, 1));
            #HALF; sclk = 1'b1;
            #HALF; sclk = 1'b0;
        end
        #(4 * HALF);
        check_regs("idle_sclk", 32'h0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vt[i].nwr; k++) exp_q.push_back(vt[i].wr[29-10*k -: 10]);
            spi_begin();
            for (int j = 0; j < vt[i].n; j++) begin
                spi_bits(vt[i].bytes[31-8*j -: 8], 8, rx_b, oe_b);
                if (vt[i].rd_chk && j > 0) begin
                    check($sformatf("vec%0d_rd_byte%0d", i, j), {24'h0, rx_b}, {24'h0, vt[i].rd[31-8*j -: 8]});
                    check($sformatf("vec%0d_miso_oe%0d", i, j), {31'h0, oe_b}, {31'h0, exp_oe});
                end
            end
            spi_end();
            check_regs($sformatf("vec%0d", i), vt[i].regs);
            check($sformatf("vec%0d_wr_drained", i), exp_q.size(), 32'h0);
        end

        // Aborted frame: 0x82 then 5 data bits, no write
        spi_begin();
        spi_bits(8'h82, 8, rx_b, oe_b);
        spi_bits(8'hFF, 5, rx_b, oe_b);
        spi_end();
        check_regs("abort", 32'hA533_0011);
        exp_q.push_back(10'h25A);
        spi_frame(32'h825A_0000, 2);
        check_regs("after_abort", 32'hA533_5A11);
        check("after_abort_wr_drained", exp_q.size(), 32'h0);

        // Reset mid-frame with ss_n held low
        spi_begin();
        spi_bits(8'h80, 8, rx_b, oe_b);
        spi_bits(8'hFF, 3, rx_b, oe_b);
        rst = 1'b1;
        #30ns;
        rst = 1'b0;
        #100ns;
        check_regs("mid_rst", 32'h0);
        check("mid_rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        spi_bits(8'hFF, 5, rx_b, oe_b);
        spi_bits(8'hC3, 8, rx_b, oe_b);
        #(4 * HALF);
        check_regs("post_rst_bits", 32'h0);
        spi_end();
        exp_q.push_back(10'h03C);
        spi_frame(32'h803C_0000, 2);
        check_regs("post_rst_frame", 32'h3C00_0000);
        check("final_wr_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI slave that receives host frames and maintains four 8-bit display registers, slv_reg0..slv_reg3.
- Sits directly upstream of the FND display path: its register outputs drive the display mux inputs.
- Oversamples SPI pins in the clk domain; SPI mode 0, MSB first.
- Supports single and auto-incrementing burst writes, plus optional readback.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  system clock, 100 MHz; must be at least 8x sclk frequency.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock (CPOL=0), asynchronous to clk.
- mosi  in  1  SPI data in.
- ss_n  in  1  SPI select, active-low.
- miso  out  1  SPI data out.
- miso_oe  out  1  tri-state enable for the board-level miso buffer.
- slv_reg0..slv_reg3  out  8 each  register contents.
- wr_pulse  out  1  one-clk strobe on every completed register write.
- wr_addr  out  2  address of the last write; valid while wr_pulse is high.

Behaviour:
- Reset:
  - slv_reg* = RESET_VAL; miso = 0, miso_oe = 0, wr_pulse = 0, wr_addr = 0.
  - FSM = IDLE; bit_cnt = 0.
- Synchronization and edge detection:
  - sclk, mosi and ss_n each pass through SYNC_STAGES flops.
  - Rising and falling edges of sclk and ss_n are detected on the synchronized signals (one-clk pulses).
- Frame format:
  - Frame opens on the ss_n falling edge.
  - Byte 0 is the command: bit7 = 1 write, 0 read; bits[1:0] = start address; bits[6:2] ignored.
  - Each following byte is one data byte.
  - Address post-increments after every data byte and wraps 3 -> 0.
- FSM states:
  - IDLE:
    - Enter CMD on a synchronized ss_n falling edge; clear bit_cnt.
    - A low ss_n without a falling edge (e.g. low coming out of reset) is ignored.
  - CMD:
    - On each sclk rising edge, shift mosi into rx_shift and increment bit_cnt.
    - On the 8th edge, latch rw and addr; clear bit_cnt; go to DATA.
    - For a read, also load tx_shift = slv_reg[addr] on the 8th edge.
  - DATA:
    - On each sclk rising edge, shift mosi into rx_shift.
    - On the 8th edge of a write: slv_reg[addr] <= completed byte, wr_pulse = 1 for one clk, wr_addr = addr, addr++.
    - On the 8th edge of a read: addr++, then load tx_shift = slv_reg[new addr].
- Write latency: the register updates within SYNC_STAGES+2 clk of the physical 8th sclk rising edge. Only one register changes per write, and it changes in a single clk.
- miso:
  - miso = tx_shift[7].
  - tx_shift shifts left on sclk falling edges in DATA only when bit_cnt != 0, so the first bit of each byte is valid before its first rising edge.
  - miso_oe = 1 while synchronized ss_n is low and FSM != IDLE; otherwise miso = 0.
- ss_n rising edge in any state:
  - FSM returns to IDLE and the partial byte is discarded.
  - No write, no wr_pulse.
  - A command-only frame is a no-op.
- sclk edges while in IDLE are ignored.
- An ss_n rising edge takes priority over an sclk edge in the same clk.
- rst asserted mid-frame:
  - Immediate return to reset values.
  - The block waits for a fresh ss_n high-to-low before decoding again.

Optional Feature:
- SPI_READBACK_EN defined:
  - Read commands shift out register contents as described above.
- SPI_READBACK_EN undefined:
  - tx path removed; miso tied to 0 and miso_oe tied to 0.
  - Read frames are consumed without effect: addr still increments, no write occurs.

Decomposition:
- Package spi_regfile_pkg holds:
  - CMD_RW_BIT = 7, ADDR_W = 2, NUM_REGS = 4, BYTE_BITS = 8.
  - FSM state encoding {IDLE, CMD, DATA}.
- One sub-module, spi_sync_edge: SYNC_STAGES-deep synchronizer with rise/fall pulse outputs.
  - One instance each for sclk and ss_n.
  - mosi uses the synchronizer only.

Test Plan:
- Reset -> all slv_reg = 8'h00; miso = 0, miso_oe = 0, wr_pulse = 0; sclk toggling with ss_n high causes no change.
- Frame 0x81, 0x2A -> slv_reg1 = 0x2A; exactly one wr_pulse with wr_addr = 1; slv_reg0/2/3 unchanged.
- Burst 0x83, 0x11, 0x22, 0x33 -> slv_reg3 = 0x11, slv_reg0 = 0x22, slv_reg1 = 0x33; three wr_pulses with wr_addr 3, 0, 1 (wrap).
- After the previous step, frame 0x01, 0x00, 0x00 with SPI_READBACK_EN defined -> miso returns 0x33 then 0x00 (slv_reg2), MSB first, sampled on sclk rising. Without the macro -> miso constant 0.
- Frame 0x82 followed by only 5 data bits, then ss_n high -> slv_reg2 unchanged, no wr_pulse. The next frame 0x82, 0x5A then writes 0x5A.
- rst pulse after 3 data bits of frame 0x80, 0xFF with ss_n held low -> all regs 0x00. The remaining bits cause no write; a new frame after an ss_n high-to-low decodes normally.
